// File: rtl/md_sequencer.sv
// md_sequencer: drives the multi-cycle multiply/divide unit for the execute stage.
// It decodes MUL/DIV in X and fires a one-cycle start pulse. It stalls F/D/X until
// the unit answers or the watchdog expires. It then presents a one-cycle writeback.
// Exceptions and timeouts redirect that writeback to rstatus (r30).
//
// Ports
//   clock, reset              : rising-edge clock, asynchronous active-high reset
//   insn_x, valid_x, flush    : instruction in X, its validity, kill from an older branch
//   md_ready, md_exception,
//   md_result                 : multdiv handshake (exception/result sampled with ready)
//   ctrl_MULT, ctrl_DIV       : one-cycle start pulses (combinational, issue cycle)
//   stall                     : hold PC, F/D, D/X; bubble into X/M (combinational)
//   wb_valid, wb_we, wb_rd,
//   wb_data                   : registered one-cycle writeback
//   busy                      : sequencer is not idle
module md_sequencer #(
    parameter int unsigned TIMEOUT     = 64,
    parameter logic [31:0] RSTATUS_MUL = 32'd1,
    parameter logic [31:0] RSTATUS_DIV = 32'd2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] insn_x,
    input  logic        valid_x,
    input  logic        flush,
    input  logic        md_ready,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        stall,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        busy
);

    localparam int unsigned CNT_W      = $clog2(TIMEOUT);
    localparam logic [4:0]  OPC_ALU    = 5'b00000;
    localparam logic [4:0]  ALU_MUL    = 5'b00110;
    localparam logic [4:0]  ALU_DIV    = 5'b00111;
    localparam logic [4:0]  RSTATUS_RD = 5'd30;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [4:0]         rd_q;
    logic               div_q;
    logic               start;
    logic               timeout;

    // Field decode of the instruction sitting in X.
    logic [4:0] opcode;
    logic [4:0] alu_op;
    logic       is_mul;
    logic       is_div;
    logic       unused_insn_bits;

    assign opcode           = insn_x[31:27];
    assign alu_op           = insn_x[6:2];
    assign is_mul           = valid_x && (opcode == OPC_ALU) && (alu_op == ALU_MUL);
    assign is_div           = valid_x && (opcode == OPC_ALU) && (alu_op == ALU_DIV);
    assign unused_insn_bits = ^{insn_x[21:7], insn_x[1:0]};

    assign timeout = (cnt == CNT_W'(TIMEOUT - 1)) && !md_ready;
    assign busy    = (state != S_IDLE);

    // Next-state and combinational start/stall.
    always_comb begin
        state_n   = state;
        start     = 1'b0;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        stall     = 1'b0;
        case (state)
            S_IDLE: begin
                if ((is_mul || is_div) && !flush) begin
                    start     = 1'b1;
                    ctrl_MULT = is_mul;
                    ctrl_DIV  = is_div;
                    stall     = 1'b1;
                    state_n   = S_WAIT;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                // flush outranks a same-cycle result or timeout
                if (flush) begin
                    state_n = S_IDLE;
                end else if (md_ready || timeout) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        // Outputs must fall while reset is held, even with an MD insn still in X.
        if (reset) begin
            start     = 1'b0;
            ctrl_MULT = 1'b0;
            ctrl_DIV  = 1'b0;
            stall     = 1'b0;
        end
    end

    // State, operation latches, watchdog counter and registered writeback.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rd_q     <= 5'd0;
            div_q    <= 1'b0;
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_rd    <= 5'd0;
            wb_data  <= 32'd0;
        end else begin
            state    <= state_n;
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_rd    <= 5'd0;
            wb_data  <= 32'd0;
            if (start) begin
                rd_q  <= insn_x[26:22];
                div_q <= is_div;
                cnt   <= '0;
            end else if (state == S_WAIT && cnt != CNT_W'(TIMEOUT - 1)) begin
                cnt <= cnt + CNT_W'(1);
            end
            // Writeback is staged on the WAIT->DONE edge so DONE presents it from flops.
            if (state == S_WAIT && state_n == S_DONE) begin
                wb_valid <= 1'b1;
                if (md_ready && !md_exception) begin
                    wb_rd   <= rd_q;
                    wb_data <= md_result;
                    wb_we   <= (rd_q != 5'd0);
                end else begin
                    wb_rd   <= RSTATUS_RD;
                    wb_data <= div_q ? RSTATUS_DIV : RSTATUS_MUL;
                    wb_we   <= 1'b1;
                end
            end
        end
    end

endmodule
